// File: rtl/i2c_tgt_pkg.sv
// Shared definitions for the I2C configuration target: FSM state encoding,
// default device address and the input-path depth constants.
package i2c_tgt_pkg;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h39;
  localparam int         FILT_LEN_DEF = 4;
  localparam int         SYNC_DEPTH   = 2;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_A,
    SUB,
    ACK_S,
    WDATA,
    ACK_W,
    RDATA,
    RACK
  } tgt_state_e;

endpackage

// File: rtl/i2c_tgt_linefilt.sv
// SCL/SDA input path: synchroniser, stability filter, then edge and
// START/STOP detection on the filtered pair. Output pulses last one cycle.
module i2c_tgt_linefilt
  import i2c_tgt_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [2*SYNC_DEPTH-1:0] r_sync;
  logic [1:0]              w_sync;     // {scl, sda}
  logic [1:0]              r_filt;
  logic [1:0]              r_filt_q;
  logic [CNT_W-1:0]        r_cnt [2];

  assign w_sync = r_sync[2*SYNC_DEPTH-1 -: 2];

  // Lines idle high, so every stage resets to 1 to avoid phantom edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '1;
      r_filt   <= 2'b11;
      r_filt_q <= 2'b11;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_sync   <= {r_sync[2*SYNC_DEPTH-3:0], i_scl, i_sda};
      r_filt_q <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(FILT_LEN - 1)) begin
          r_filt[i] <= w_sync[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_sda      = r_filt[0];
  assign o_scl_rise =  r_filt[1] & ~r_filt_q[1];
  assign o_scl_fall = ~r_filt[1] &  r_filt_q[1];
  assign o_start    = r_filt[1] & r_filt_q[1] &  r_filt_q[0] & ~r_filt[0];
  assign o_stop     = r_filt[1] & r_filt_q[1] & ~r_filt_q[0] &  r_filt[0];

endmodule

// File: rtl/i2c_cfg_target.sv
// I2C write target with a 256x8 register file and host side read port.
// Define I2C_TGT_READ_EN to also serve controller reads (R/W=1) from the file.
module i2c_cfg_target
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int         FILT_LEN = FILT_LEN_DEF
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy
);

  tgt_state_e r_state, w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic [7:0] r_mem [256];
  logic       w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic       w_last, w_addr_hit, w_rx_state, w_wr_en;
`ifdef I2C_TGT_READ_EN
  logic [7:0] r_tx;
  logic       r_rd;
  logic       w_tx_shift;
`endif

  i2c_tgt_linefilt #(.FILT_LEN(FILT_LEN)) u_linefilt (
    .i_clk      (iCLK),
    .i_rst_n    (iRST_N),
    .i_scl      (I2C_SCL),
    .i_sda      (I2C_SDA),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign I2C_SDA    = r_sda_oe ? 1'b0 : 1'bz;
  assign busy       = (r_state != IDLE);
  assign w_byte     = {r_shift, w_sda};
  assign w_last     = (r_bit_cnt == 3'd7);
  assign w_rx_state = r_state inside {ADDR, SUB, WDATA, RDATA};
  assign w_wr_en    = w_scl_rise && w_last && (r_state == WDATA);
`ifdef I2C_TGT_READ_EN
  assign w_addr_hit = (w_byte[7:1] == DEV_ADDR);
`else
  assign w_addr_hit = (w_byte[7:1] == DEV_ADDR) && !w_byte[0];
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latches).
    w_state_nxt  = r_state;
    w_sda_oe_nxt = r_sda_oe;
`ifdef I2C_TGT_READ_EN
    w_tx_shift   = 1'b0;
`endif
    if (w_stop) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ADDR;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        ADDR:  if (w_scl_rise && w_last) w_state_nxt = w_addr_hit ? ACK_A : IDLE;
        SUB:   if (w_scl_rise && w_last) w_state_nxt = ACK_S;
        WDATA: if (w_scl_rise && w_last) w_state_nxt = ACK_W;
        ACK_A, ACK_S, ACK_W: begin
          // First SCL fall grabs SDA for the ACK clock, the second lets it go.
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = (r_state == ACK_A) ? SUB : WDATA;
`ifdef I2C_TGT_READ_EN
              if (r_state == ACK_A && r_rd) begin
                w_state_nxt  = RDATA;
                w_sda_oe_nxt = ~r_tx[7];
                w_tx_shift   = 1'b1;
              end
`endif
            end
          end
        end
`ifdef I2C_TGT_READ_EN
        RDATA: if (w_scl_fall) begin
          if (r_bit_cnt == 3'd0) begin
            w_sda_oe_nxt = 1'b0;
            w_state_nxt  = RACK;
          end else begin
            w_sda_oe_nxt = ~r_tx[7];
            w_tx_shift   = 1'b1;
          end
        end
        RACK: begin
          if (w_scl_rise && w_sda) begin
            w_state_nxt = IDLE;
          end else if (w_scl_fall) begin
            w_state_nxt  = RDATA;
            w_sda_oe_nxt = ~r_tx[7];
            w_tx_shift   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      r_sda_oe <= w_sda_oe_nxt;
      wr_stb   <= 1'b0;
      if (w_start || w_stop) begin
        r_bit_cnt <= '0;
      end else if (w_scl_rise && w_rx_state) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_byte[6:0];
        if (w_last) begin
          if (r_state == SUB) r_ptr <= w_byte;
          if (r_state == WDATA || r_state == RDATA) r_ptr <= r_ptr + 8'd1;
          if (r_state == WDATA) begin
            wr_stb  <= 1'b1;
            wr_addr <= r_ptr;
            wr_data <= w_byte;
          end
        end
      end
    end
  end

`ifdef I2C_TGT_READ_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_tx <= '0;
      r_rd <= 1'b0;
    end else if (r_state == ADDR && w_scl_rise && w_last && !w_start && !w_stop) begin
      r_rd <= w_byte[0];
      r_tx <= r_mem[r_ptr];
    end else if (r_state == RACK && w_scl_rise) begin
      r_tx <= r_mem[r_ptr];
    end else if (w_tx_shift) begin
      r_tx <= {r_tx[6:0], 1'b0};
    end
  end
`endif

  // NOTE: the register file is RAM and is deliberately left without a reset.
  always_ff @(posedge iCLK) begin
    if (w_wr_en) r_mem[r_ptr] <= w_byte;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) rd_data <= '0;
    else         rd_data <= r_mem[rd_addr];
  end

endmodule

// File: tb/tb_i2c_cfg_target.sv
// Bench for i2c_cfg_target: bit-banged I2C controller plus a register-file and
// pointer model; directed spec scenarios followed by randomized write frames.
module tb_i2c_cfg_target;

  localparam int         Q   = 10;      // quarter SCL period in clk cycles
  localparam logic [6:0] DEV = 7'h39;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda_low;
  wire        sda;
  logic       wr_stb;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       busy;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  i2c_cfg_target dut (
    .iCLK    (clk),
    .iRST_N  (rst_n),
    .I2C_SCL (m_scl),
    .I2C_SDA (sda),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  // Reference model: register file contents, which entries are known, sub-address pointer.
  logic [7:0]  ref_mem [256];
  bit          ref_known [256];
  int          ref_ptr;
  logic [15:0] exp_q [$];
  logic [15:0] stb_q [$];
  logic [7:0]  fdata [$];
  int          written [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge clk) if (wr_stb === 1'b1) stb_q.push_back({wr_addr, wr_data});

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 90000 cycles, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_q();
    m_scl     = 1'b1; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl     = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl     = 1'b1; wait_q();
    m_sda_low = 1'b0; wait_q();
    wait_q();
  endtask

  // glitch: invert SDA for one clk cycle in the middle of the SCL-high phase
  task automatic write_bit(input logic b, input bit glitch);
    m_sda_low = ~b; wait_q();
    m_scl     = 1'b1;
    wait_q();
    if (glitch) begin
      m_sda_low = b;
      @(negedge clk);
      m_sda_low = ~b;
      repeat (Q - 1) @(negedge clk);
    end else begin
      wait_q();
    end
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_bit);
    m_sda_low = 1'b0; wait_q();
    m_scl     = 1'b1; wait_q();
    ack       = (sda == 1'b0);
    wait_q();
    m_scl     = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wait_q(); m_scl = 1'b1;
      wait_q(); d[i] = sda;
      wait_q(); m_scl = 1'b0;
    end
    m_sda_low = send_ack; wait_q();
    m_scl     = 1'b1; wait_q(); wait_q();
    m_scl     = 1'b0; wait_q();
    m_sda_low = 1'b0;
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_nstb"}, stb_q.size(), exp_q.size());
    while (exp_q.size() > 0 && stb_q.size() > 0)
      check({tag, "_stb"}, stb_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    stb_q.delete();
  endtask

  task automatic read_check(input string tag, input logic [7:0] a);
    @(negedge clk); rd_addr = a;
    @(negedge clk);
    check(tag, rd_data, ref_mem[a]);
  endtask

  // Full write frame: device address, sub-address, then every byte in fdata.
  task automatic write_frame(input string tag, input logic [7:0] sub, input int glitch_bit);
    logic ack;
    i2c_start();
    write_byte({DEV, 1'b0}, -1, ack); check({tag, "_ack_dev"}, ack, 1);
    write_byte(sub, -1, ack);         check({tag, "_ack_sub"}, ack, 1);
    ref_ptr = sub;
    foreach (fdata[i]) begin
      write_byte(fdata[i], glitch_bit, ack);
      check({tag, "_ack_data"}, ack, 1);
      exp_q.push_back({ref_ptr[7:0], fdata[i]});
      ref_mem[ref_ptr]   = fdata[i];
      ref_known[ref_ptr] = 1'b1;
      written.push_back(ref_ptr);
      ref_ptr = (ref_ptr + 1) % 256;
    end
    i2c_stop();
    check({tag, "_busy_end"}, busy, 0);
    check_strobes(tag);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] b;

    rst_n = 1'b0; m_scl = 1'b1; m_sda_low = 1'b0; rd_addr = '0; ref_ptr = 0;
    repeat (3) @(negedge clk);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda, 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single write
    fdata = '{8'hA5};
    write_frame("single", 8'h15, -1);
    read_check("single_rd", 8'h15);

    // Burst across the pointer wrap
    fdata = '{8'h11, 8'h22, 8'h33};
    write_frame("burst", 8'hFE, -1);
    read_check("burst_rd_fe", 8'hFE);
    read_check("burst_rd_ff", 8'hFF);
    read_check("burst_rd_00", 8'h00);

    // Foreign address: no ACK, bus released, no strobe
    i2c_start();
    write_byte(8'h74, -1, ack);
    check("foreign_ack", ack, 0);
    check("foreign_busy", busy, 0);
    i2c_stop();
    check_strobes("foreign");

    // Frame aborted mid-byte
    fdata = '{8'h5C};
    write_frame("prefill20", 8'h20, -1);
    i2c_start();
    write_byte({DEV, 1'b0}, -1, ack); check("partial_ack_dev", ack, 1);
    write_byte(8'h20, -1, ack);       check("partial_ack_sub", ack, 1);
    ref_ptr = 8'h20;
    b = 8'hC3;
    for (int i = 7; i >= 4; i--) write_bit(b[i], 1'b0);
    i2c_stop();
    check("partial_busy", busy, 0);
    check_strobes("partial");
    read_check("partial_rd", 8'h20);

    // One-cycle SDA glitch with the bus idle must not start a frame
    @(negedge clk); m_sda_low = 1'b1;
    @(negedge clk); m_sda_low = 1'b0;
    repeat (2 * Q) @(negedge clk);
    check("glitch_idle_busy", busy, 0);

    // Glitches inside data bits (a fake STOP on a 0, a fake START on a 1)
    fdata = '{8'h4B, 8'hC0};
    write_frame("glitch_data", 8'h30, 7);
    read_check("glitch_rd30", 8'h30);
    read_check("glitch_rd31", 8'h31);

    // Reset while the target holds the ACK low
    i2c_start();
    b = {DEV, 1'b0};
    for (int i = 7; i >= 0; i--) write_bit(b[i], 1'b0);
    m_sda_low = 1'b0; wait_q();
    m_scl     = 1'b1; wait_q();
    check("rstack_held", sda, 0);
    rst_n = 1'b0;
    #1;
    check("rstack_sda", sda, 1);
    check("rstack_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ref_ptr = 0;
    repeat (2 * Q) @(negedge clk);
    check_strobes("rstack");

`ifdef I2C_TGT_READ_EN
    fdata = '{8'($urandom), 8'($urandom)};
    write_frame("rdfill", 8'h40, -1);
    i2c_start();
    write_byte({DEV, 1'b0}, -1, ack); check("rd_ack_dev", ack, 1);
    write_byte(8'h40, -1, ack);       check("rd_ack_sub", ack, 1);
    ref_ptr = 8'h40;
    i2c_start();
    write_byte({DEV, 1'b1}, -1, ack); check("rd_ack_rdaddr", ack, 1);
    read_byte(1'b1, d); check("rd_byte0", d, ref_mem[ref_ptr]); ref_ptr = (ref_ptr + 1) % 256;
    read_byte(1'b0, d); check("rd_byte1", d, ref_mem[ref_ptr]); ref_ptr = (ref_ptr + 1) % 256;
    check("rd_busy_after_nack", busy, 0);
    i2c_stop();
    check_strobes("rd");
`else
    i2c_start();
    write_byte({DEV, 1'b1}, -1, ack);
    check("noread_ack", ack, 0);
    check("noread_busy", busy, 0);
    i2c_stop();
    check_strobes("noread");
`endif

    // Randomized frames against the model
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        logic [6:0] a7;
        a7 = 7'($urandom);
        if (a7 == DEV) a7 = a7 ^ 7'h01;
        i2c_start();
        write_byte({a7, 1'($urandom)}, -1, ack);
        check("rand_foreign_ack", ack, 0);
        i2c_stop();
        check_strobes("rand_foreign");
      end else begin
        fdata.delete();
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) fdata.push_back(8'($urandom));
        write_frame("rand", 8'($urandom), -1);
      end
    end
    for (int k = 0; k < 8 && written.size() > 0; k++)
      read_check("rand_rd", 8'(written[$urandom_range(0, written.size() - 1)]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
